// File: rtl/clk_rate_sequencer.sv
// rtl/clk_rate_sequencer.sv - programmable square-wave clock sequencer with burst/stop control
//
// Purpose:
//   Divides the 100 MHz board clock into a 50% duty square wave whose
//   half-period and burst length are loaded at runtime. Rate changes made
//   while running are staged and only applied on a falling edge of the output,
//   so the generated clock never carries a runt pulse.
//
// Ports:
//   incoming_CLK100MHZ  in   system clock
//   rst                 in   asynchronous active-high reset
//   cfg_half            in   requested half-period minus 1
//   cfg_count           in   periods per run, 0 = free-run
//   cfg_valid           in   config offer
//   cfg_ready           out  config slot free
//   start               in   begin generation (level)
//   stop                in   graceful stop request
//   outgoing_CLK        out  generated clock (registered)
//   tick                out  pulse in the cycle outgoing_CLK rises
//   busy                out  high while running or finishing
//   done                out  pulse in the cycle a run ends
//   period_cnt          out  completed periods since last run entry
//                            (only when CLK_SEQ_STATUS_EN is defined)
//
// Build option:
//   CLK_SEQ_STATUS_EN   adds the period_cnt status output.

module clk_rate_sequencer #(
  parameter int CTR_W        = 27,
  parameter int DEFAULT_HALF = 49_999,
  parameter int CNT_W        = 16
) (
  input  logic             incoming_CLK100MHZ,
  input  logic             rst,
  input  logic [CTR_W-1:0] cfg_half,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  output logic             outgoing_CLK,
  output logic             tick,
  output logic             busy,
  output logic             done
`ifdef CLK_SEQ_STATUS_EN
  ,
  output logic [CNT_W-1:0] period_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t             r_state;
  logic [CTR_W-1:0]   r_ctr;
  logic               r_clk;
  logic               r_tick;
  logic               r_busy;
  logic               r_done;
  logic               r_cfg_ready;
  logic [CTR_W-1:0]   r_active_half;
  logic [CNT_W-1:0]   r_active_count;
  logic [CTR_W-1:0]   r_pend_half;
  logic [CNT_W-1:0]   r_pend_count;
  logic               r_pend_valid;
  logic [CNT_W-1:0]   r_remaining;
  logic               r_stop_flag;
`ifdef CLK_SEQ_STATUS_EN
  logic [CNT_W-1:0]   r_period_cnt;
`endif

  logic               w_cfg_fire;
  logic               w_at_half;
  logic               w_boundary;
  logic [CNT_W-1:0]   w_rem_a;
  logic [CNT_W-1:0]   w_rem_b;
  logic               w_burst_end;
  logic               w_run_end;

  assign w_cfg_fire = cfg_valid & r_cfg_ready;
  assign w_at_half  = (r_ctr == r_active_half);
  // The period boundary is the high-to-low transition of the output.
  assign w_boundary = (r_state != S_IDLE) && w_at_half && r_clk;

  // Remaining count after the staged config is applied: a staged count only
  // replaces it when the run is free-running (remaining already 0).
  assign w_rem_a     = (r_pend_valid && (r_remaining == '0)) ? r_pend_count : r_remaining;
  assign w_burst_end = (w_rem_a == CNT_W'(1));
  assign w_rem_b     = (w_rem_a != '0) ? (w_rem_a - CNT_W'(1)) : '0;
  assign w_run_end   = w_boundary && (w_burst_end || r_stop_flag);

  always_ff @(posedge incoming_CLK100MHZ or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_ctr          <= '0;
      r_clk          <= 1'b0;
      r_tick         <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_cfg_ready    <= 1'b1;
      r_active_half  <= CTR_W'(DEFAULT_HALF);
      r_active_count <= '0;
      r_pend_half    <= '0;
      r_pend_count   <= '0;
      r_pend_valid   <= 1'b0;
      r_remaining    <= '0;
      r_stop_flag    <= 1'b0;
`ifdef CLK_SEQ_STATUS_EN
      r_period_cnt   <= '0;
`endif
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clk <= 1'b0;
          r_ctr <= '0;
          // A config staged in the last running cycle is flushed here so the
          // slot never stays occupied while idle.
          if (r_pend_valid) begin
            r_active_half  <= r_pend_half;
            r_active_count <= r_pend_count;
            r_pend_valid   <= 1'b0;
            r_cfg_ready    <= 1'b1;
          end else if (w_cfg_fire) begin
            r_active_half  <= cfg_half;
            r_active_count <= cfg_count;
          end
          if (start && !stop) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_remaining <= r_pend_valid ? r_pend_count : r_active_count;
            r_stop_flag <= 1'b0;
`ifdef CLK_SEQ_STATUS_EN
            r_period_cnt <= '0;
`endif
          end
        end

        S_RUN, S_FINISH: begin
          if (w_at_half) begin
            r_ctr  <= '0;
            r_clk  <= ~r_clk;
            r_tick <= ~r_clk;
          end else begin
            r_ctr <= r_ctr + CTR_W'(1);
          end

          if (w_boundary) begin
            if (r_pend_valid) begin
              r_active_half  <= r_pend_half;
              r_active_count <= r_pend_count;
              r_pend_valid   <= 1'b0;
              r_cfg_ready    <= 1'b1;
            end
            r_remaining <= w_rem_b;
`ifdef CLK_SEQ_STATUS_EN
            if (r_period_cnt != '1) begin
              r_period_cnt <= r_period_cnt + CNT_W'(1);
            end
`endif
          end

          // Accepting requires an empty slot, so this never collides with the
          // boundary transfer above; a config taken on a boundary waits for
          // the following one.
          if (w_cfg_fire) begin
            r_pend_half  <= cfg_half;
            r_pend_count <= cfg_count;
            r_pend_valid <= 1'b1;
            r_cfg_ready  <= 1'b0;
          end

          if (w_run_end) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_stop_flag <= 1'b0;
          end else if ((r_state == S_RUN) && stop) begin
            r_stop_flag <= 1'b1;
            r_state     <= S_FINISH;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_clk   <= 1'b0;
          r_ctr   <= '0;
        end
      endcase
    end
  end

  assign outgoing_CLK = r_clk;
  assign tick         = r_tick;
  assign busy         = r_busy;
  assign done         = r_done;
  assign cfg_ready    = r_cfg_ready;
`ifdef CLK_SEQ_STATUS_EN
  assign period_cnt   = r_period_cnt;
`endif

endmodule

// File: tb/tb_clk_rate_sequencer.sv
// tb/tb_clk_rate_sequencer.sv - directed self-checking bench for clk_rate_sequencer

module tb_clk_rate_sequencer;

  logic        clk;
  logic        rst;
  logic [26:0] cfg_half;
  logic [15:0] cfg_count;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        start;
  logic        stop;
  logic        outgoing_CLK;
  logic        tick;
  logic        busy;
  logic        done;
`ifdef CLK_SEQ_STATUS_EN
  logic [15:0] period_cnt;
`endif

  int checks;
  int errors;

  clk_rate_sequencer dut (
    .incoming_CLK100MHZ (clk),
    .rst                (rst),
    .cfg_half           (cfg_half),
    .cfg_count          (cfg_count),
    .cfg_valid          (cfg_valid),
    .cfg_ready          (cfg_ready),
    .start              (start),
    .stop               (stop),
    .outgoing_CLK       (outgoing_CLK),
    .tick               (tick),
    .busy               (busy),
    .done               (done)
`ifdef CLK_SEQ_STATUS_EN
    ,
    .period_cnt         (period_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cfg_write(input logic [26:0] h, input logic [15:0] n);
    cfg_half  = h;
    cfg_count = n;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
  endtask

  // Returns at the negedge of RUN cycle 0.
  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    int   found;
    logic seen;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({outgoing_CLK, tick, busy, done, cfg_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_state {clk,tick,busy,done,ready} got %b exp 00001",
               {outgoing_CLK, tick, busy, done, cfg_ready});
    end
    rst = 1'b0;
    @(negedge clk);

    cfg_write(27'd1, 16'd0);
    start_run();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (outgoing_CLK) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_prep_rise got no rise exp rise within 10 cycles");
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({outgoing_CLK, tick, busy, done, cfg_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_async {clk,tick,busy,done,ready} got %b exp 00001",
               {outgoing_CLK, tick, busy, done, cfg_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    start_run();
    found = -1;
    for (int i = 0; i < 60000; i++) begin
      if (outgoing_CLK) begin
        found = i;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (found != 50000) begin
      errors++;
      $display("FAIL reset_default_rate first rise cycle got %0d exp 50000", found);
    end
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL reset_default_tick got %b exp 1", tick);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_burst();
    logic [3:0] e;
    int         ticks;
    cfg_write(27'd1, 16'd3);
    start_run();
    ticks = 0;
    for (int c = 0; c < 16; c++) begin
      e[3] = (c < 12) && ((c % 4) >= 2);
      e[2] = (c == 2) || (c == 6) || (c == 10);
      e[1] = (c == 12);
      e[0] = (c < 12);
      checks++;
      if ({outgoing_CLK, tick, done, busy} !== e) begin
        errors++;
        $display("FAIL burst c=%0d {clk,tick,done,busy} got %b exp %b",
                 c, {outgoing_CLK, tick, done, busy}, e);
      end
      if (tick === 1'b1) ticks++;
      @(negedge clk);
    end
    checks++;
    if (ticks != 3) begin
      errors++;
      $display("FAIL burst_tick_count got %0d exp 3", ticks);
    end
  endtask

  task automatic test_rate_change();
    logic [2:0] e;
    logic       seen;
    cfg_write(27'd3, 16'd0);
    start_run();
    for (int c = 0; c < 24; c++) begin
      e[2] = (c < 16) ? ((c % 8) >= 4) : (((c - 16) % 2) == 1);
      e[1] = (c == 4) || (c == 12) || ((c >= 17) && ((c % 2) == 1));
      e[0] = !((c >= 10) && (c <= 15));
      checks++;
      if ({outgoing_CLK, tick, cfg_ready} !== e) begin
        errors++;
        $display("FAIL rate_change c=%0d {clk,tick,ready} got %b exp %b",
                 c, {outgoing_CLK, tick, cfg_ready}, e);
      end
      if (c == 9) begin
        cfg_half  = 27'd0;
        cfg_count = 16'd0;
        cfg_valid = 1'b1;
      end
      if (c == 10) cfg_valid = 1'b0;
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!(seen && (outgoing_CLK === 1'b0) && (busy === 1'b0))) begin
      errors++;
      $display("FAIL rate_change_stop done=%b clk=%b busy=%b exp done seen, clk 0, busy 0",
               seen, outgoing_CLK, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_stop();
    logic [3:0] e;
    cfg_write(27'd4, 16'd0);
    start_run();
    for (int c = 0; c < 30; c++) begin
      e[3] = (c < 20) && ((c % 10) >= 5);
      e[2] = (c == 5) || (c == 15);
      e[1] = (c == 20);
      e[0] = (c < 20);
      checks++;
      if ({outgoing_CLK, tick, done, busy} !== e) begin
        errors++;
        $display("FAIL stop c=%0d {clk,tick,done,busy} got %b exp %b",
                 c, {outgoing_CLK, tick, done, busy}, e);
      end
      if (c == 17) stop = 1'b1;
      if (c == 18) stop = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] e;
    int         dones;
    start = 1'b1;
    stop  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, outgoing_CLK, tick} !== 3'b000) begin
        errors++;
        $display("FAIL start_stop_idle i=%0d {busy,clk,tick} got %b exp 000",
                 i, {busy, outgoing_CLK, tick});
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);

    cfg_write(27'd1, 16'd2);
    start_run();
    dones = 0;
    for (int c = 0; c < 16; c++) begin
      e[1] = (c < 8) && ((c % 4) >= 2);
      e[0] = (c == 8);
      checks++;
      if ({outgoing_CLK, done} !== e) begin
        errors++;
        $display("FAIL burst_stop c=%0d {clk,done} got %b exp %b",
                 c, {outgoing_CLK, done}, e);
      end
      if (done === 1'b1) dones++;
      if (c == 6) stop = 1'b1;
      if (c == 7) stop = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL burst_stop_done_count got %0d exp 1", dones);
    end
  endtask

`ifdef CLK_SEQ_STATUS_EN
  task automatic test_status();
    int found;
    cfg_write(27'd0, 16'd5);
    start_run();
    found = -1;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        found = c;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (found != 10) begin
      errors++;
      $display("FAIL status_done_cycle got %0d exp 10", found);
    end
    checks++;
    if (period_cnt !== 16'd5) begin
      errors++;
      $display("FAIL status_count got %0d exp 5", period_cnt);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (period_cnt !== 16'd5) begin
      errors++;
      $display("FAIL status_hold got %0d exp 5", period_cnt);
    end
    start_run();
    checks++;
    if (period_cnt !== 16'd0) begin
      errors++;
      $display("FAIL status_clear got %0d exp 0", period_cnt);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (period_cnt !== 16'd1) begin
      errors++;
      $display("FAIL status_first_period got %0d exp 1", period_cnt);
    end
    repeat (12) @(negedge clk);
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    cfg_half  = '0;
    cfg_count = '0;
    cfg_valid = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    test_reset();
    test_burst();
    test_rate_change();
    test_stop();
    test_simultaneous();
`ifdef CLK_SEQ_STATUS_EN
    test_status();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_rate_sequencer.md
Name: clk_rate_sequencer

Overview:
- Programmable clock-divider controller. Produces a square-wave clock from the 100 MHz board clock.
- Rate (half-period) and burst length are set at runtime through a valid/ready config port. Start/stop control sequences the output.
- A new rate takes effect only at a period boundary, so the output never carries a runt pulse.
- Sits between the user-control logic and downstream consumers (LEDs, PMOD JA pins, slow FSMs) and replaces the fixed-rate dividers.

Parameters:
- CTR_W, 27, counter width; covers down to 1 Hz (half-period 49_999_999).
- DEFAULT_HALF, 49_999, half-period minus 1 loaded at reset (1 kHz output).
- CNT_W, 16, burst-count width.

Ports:
- incoming_CLK100MHZ  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- cfg_half  input  CTR_W  requested half-period minus 1.
- cfg_count  input  CNT_W  periods per run; 0 = free-run.
- cfg_valid  input  1  config offer.
- cfg_ready  output  1  config slot free.
- start  input  1  begin generation (level sampled each cycle).
- stop  input  1  request graceful stop.
- outgoing_CLK  output  1  generated clock, registered.
- tick  output  1  one-cycle pulse in the same cycle outgoing_CLK rises.
- busy  output  1  high in RUN and FINISH.
- done  output  1  one-cycle pulse when a run ends.

Behaviour:
- Reset (async, any state):
  - outgoing_CLK, tick, busy, done = 0; cfg_ready = 1.
  - ctr = 0; state = IDLE.
  - active_half = DEFAULT_HALF; active_count = 0; pending slot empty.
- Config handshake: transfer when cfg_valid & cfg_ready.
  - In IDLE: values are written straight into active_half/active_count next cycle. The pending slot is not used and cfg_ready stays 1.
  - In RUN/FINISH: values go into the pending slot and cfg_ready drops to 0 the next cycle.
  - Pending contents move to active at the next period boundary. cfg_ready returns to 1 the cycle after that.
- States: IDLE, RUN, FINISH.
- IDLE:
  - outgoing_CLK = 0, ctr held at 0.
  - start = 1 and stop = 0 -> RUN next cycle, with remaining = active_count.
  - start and stop together -> stop wins; stay in IDLE.
- RUN counting:
  - ctr increments each cycle.
  - When ctr == active_half: ctr <= 0 and outgoing_CLK toggles.
  - Period = 2*(active_half+1) cycles, duty 50%. active_half = 0 gives 50 MHz.
  - First rising edge comes active_half+1 cycles after RUN entry.
- Period boundary = the cycle outgoing_CLK falls (1 -> 0). At each boundary, in this order:
  - a) Apply pending config (rate only; a new cfg_count loads remaining only if the run is free-running).
  - b) If burst (remaining != 0), decrement remaining. If it reaches 0 -> IDLE with done pulse.
  - c) If stop was latched -> IDLE with done pulse.
- stop in RUN: latched into a stop flag and the state becomes FINISH. The current period completes fully, then IDLE with done. start in RUN/FINISH is ignored.
- done coincides with the falling edge of outgoing_CLK. busy falls in the same cycle as done.
- Burst ending and stop on the same boundary: a single done pulse.
- cfg accepted in the same cycle as the boundary: lands in pending and is applied at the following boundary.
- tick never asserts in IDLE. outgoing_CLK is always 0 in IDLE.
- Counter compares use full CTR_W width; the counter does not wrap past active_half.

Optional Feature:
- Macro: CLK_SEQ_STATUS_EN.
- Defined:
  - Adds output period_cnt (CNT_W): completed periods since last RUN entry.
  - Cleared on RUN entry and on reset; increments at each period boundary; saturates at all-ones.
  - Holds its value in IDLE.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst mid-RUN with outgoing_CLK = 1 -> all outputs 0 immediately; after release, start gives a DEFAULT_HALF-rate clock (first rise 50_000 cycles after RUN entry).
- Burst: IDLE config half = 1, count = 3, then start -> rises at RUN cycles 2, 6, 10; tick at each; done and IDLE at cycle 12; exactly 3 ticks.
- Rate change: free-run half = 3; during RUN send half = 0 -> cfg_ready low until the next falling edge; prior period stays 8 cycles, subsequent periods 2 cycles, no runt pulse.
- Stop: free-run half = 4; pulse stop 2 cycles after a rise -> output completes the 10-cycle period; done on the fall; busy 0; no further ticks.
- Simultaneous: start and stop high together in IDLE -> stays IDLE, no tick. Burst end and stop on the same boundary -> single done pulse.
- With CLK_SEQ_STATUS_EN: count = 5, half = 0 -> period_cnt reads 5 after done and holds; restart clears it to 0.
